dragster_spi_readback: RTL and testbench
========================================

Name: dragster_spi_readback

Overview:
- Return-path companion to the Dragster SPI forwarding adapter.
- Captures words that the Dragster sensor shifts out on external_miso during forwarded frames, and buffers each word with its slave-select tag.
- Replays buffered words to the internal AXI Quad SPI master on internal_miso during later internal frames.
- Runs in a single system clock domain; both SPI clocks are oversampled.

Parameters:
- DATA_WIDTH, 16: bits per word; LSB first on both sides.
- FIFO_DEPTH, 16: number of buffered words; range 2..255.
- IDLE_WORD, 0: word served when no valid buffered word is available (DATA_WIDTH bits).

Ports:
- clk  in  1  system clock; must be >= 4x either SPI SCK.
- reset  in  1  asynchronous, active-low reset.
- external_sck  in  1  sensor-side SCK; sampled.
- external_ss  in  2  sensor-side selects; 2'b11 = idle.
- external_miso  in  1  sensor data toward this block.
- internal_sck  in  1  AXI Quad SPI SCK; sampled.
- internal_ss  in  2  AXI Quad SPI selects; 2'b11 = idle.
- internal_miso  out  1  data toward the AXI Quad SPI master.
- buffered_count  out  8  FIFO occupancy.
- overflow  out  1  sticky; set when a captured word is dropped.

Behaviour:
- Reset (reset low, asynchronous): FIFO empty, read/write pointers 0, both FSMs in IDLE. Outputs: internal_miso=0, buffered_count=0, overflow=0.
- Synchronisers: every SPI input passes through a 2-FF synchroniser. A rising or falling edge is detected from the 2nd/3rd stage, giving a 1-clk strobe.
- Capture FSM states: CIDLE, CSHIFT, CWAIT.
  - CIDLE -> CSHIFT when synced external_ss != 3. Latch the tag as external_ss and clear the bit index.
  - CSHIFT: on each external_sck rising strobe, store synced external_miso at the bit index, then increment the index.
  - After the DATA_WIDTH-th bit: push {tag, word} on the next clk, then go to CWAIT.
  - CWAIT: ignore further SCK edges (extended clocks). Go to CIDLE when external_ss == 3.
  - external_ss == 3 while in CSHIFT: abort to CIDLE. The partial word is discarded; nothing is pushed.
  - Push with FIFO full: word dropped, overflow <= 1 (cleared only by reset), pointers unchanged.
- Serve FSM states: SIDLE, SSHIFT, SDONE.
  - SIDLE -> SSHIFT when synced internal_ss != 3.
  - Word selection at frame start: if the FIFO is non-empty, select the head word and set serve_valid=1. Otherwise select IDLE_WORD and set serve_valid=0.
  - internal_miso = selected bit 0 within 3 clk of the raw internal_ss assertion.
  - SSHIFT: each internal_sck falling strobe advances the bit index, and internal_miso presents the next bit.
  - After DATA_WIDTH falling strobes go to SDONE. If serve_valid=1, pop the head (1 clk).
  - SDONE -> SIDLE when internal_ss == 3; internal_miso returns to 0.
  - internal_ss == 3 before DATA_WIDTH bits: abort to SIDLE, no pop, head word retained for the next frame.
- Pointers wrap FIFO_DEPTH-1 -> 0.
- Push and pop in the same clk: both take effect, buffered_count unchanged.
- Pop with buffered_count == 0 cannot occur because serve_valid gates it.
- buffered_count is registered, updated 1 clk after the push/pop.
- Both FSMs run independently; capture and serve may overlap.

Optional Feature:
- Macro: DRAGSTER_READBACK_SLAVE_MATCH_EN.
- Defined: at serve-frame start the head word is selected only when its stored tag equals the synced internal_ss. On mismatch, IDLE_WORD is served, serve_valid=0, and the head is retained.
- Not defined: tags are stored but ignored; the head word is always served when the FIFO is non-empty.

Test Plan:
- Capture then serve: external frame ss=2'b10 shifting 16'hA5C3 LSB first, then an internal frame ss=2'b10 with 16 SCKs -> internal_miso carries 16'hA5C3 LSB first; buffered_count goes 0->1->0.
- Empty serve: internal frame with an empty FIFO and IDLE_WORD=16'h0000 -> 16 zero bits; buffered_count stays 0; no pointer change.
- Abort handling:
  - External frame deasserted after 7 bits -> no push, buffered_count=0.
  - Internal frame deasserted after 9 bits of a buffered 16'h1234 -> no pop; the next full frame returns 16'h1234.
- Overflow and wrap: push 17 words 16'h0001..16'h0011 with FIFO_DEPTH=16 -> overflow=1, buffered_count=16. Serve 16 frames -> 16'h0001..16'h0010 in order. Then push/serve 16'h0042 across the pointer wrap -> served correctly.
- Concurrency and extended clocks: internal serve frame overlapping an external capture frame that has 3 extended SCKs -> one push, one pop, count unchanged, extended clocks ignored, no corruption of the served bits.
- Reset mid-frame: assert reset during both FSMs' SSHIFT/CSHIFT -> internal_miso=0, buffered_count=0, overflow=0 immediately. With DRAGSTER_READBACK_SLAVE_MATCH_EN defined, a head tagged 2'b01 served to ss=2'b10 -> IDLE_WORD, count unchanged.

Source files
------------

// File: rtl/dragster_spi_readback_if.sv
// Port bundle for dragster_spi_readback: sensor-side capture bus, AXI Quad SPI serve bus,
// status outputs and FSM state visibility. The DUT takes the slave modport.
interface dragster_spi_readback_if;
    logic       external_sck;
    logic [1:0] external_ss;
    logic       external_miso;
    logic       internal_sck;
    logic [1:0] internal_ss;
    logic       internal_miso;
    logic [7:0] buffered_count;
    logic       overflow;
    logic [1:0] capture_state;
    logic [1:0] serve_state;

    modport master (
        output external_sck, external_ss, external_miso,
        output internal_sck, internal_ss,
        input  internal_miso, buffered_count, overflow,
        input  capture_state, serve_state
    );

    modport slave (
        input  external_sck, external_ss, external_miso,
        input  internal_sck, internal_ss,
        output internal_miso, buffered_count, overflow,
        output capture_state, serve_state
    );
endinterface

// File: rtl/dragster_spi_readback.sv
// Dragster SPI readback: captures sensor words into a tagged FIFO and replays them to the
// AXI Quad SPI master. Optional DRAGSTER_READBACK_SLAVE_MATCH_EN gates serving on tag match.
module dragster_spi_readback #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    FIFO_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '0
) (
    input logic                    clk,
    input logic                    reset,
    dragster_spi_readback_if.slave bus
);

    localparam int IDX_W   = $clog2(DATA_WIDTH + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = DATA_WIDTH + 2;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [7:0]       DEPTH_CNT = 8'(FIFO_DEPTH);
    localparam logic [1:0]       SS_IDLE   = 2'b11;

    typedef enum logic [1:0] {
        CIDLE  = 2'd0,
        CSHIFT = 2'd1,
        CWAIT  = 2'd2
    } cap_state_e;

    typedef enum logic [1:0] {
        SIDLE  = 2'd0,
        SSHIFT = 2'd1,
        SDONE  = 2'd2
    } srv_state_e;

    // ------------------------------------------------------------------
    // Input synchronisers; SCK keeps a third stage for edge detection
    // ------------------------------------------------------------------
    logic [2:0] esck_q;
    logic [2:0] isck_q;
    logic [1:0] emiso_q;
    logic [1:0] ess_s1_q, ess_s2_q;
    logic [1:0] iss_s1_q, iss_s2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            esck_q   <= '0;
            isck_q   <= '0;
            emiso_q  <= '0;
            ess_s1_q <= SS_IDLE;
            ess_s2_q <= SS_IDLE;
            iss_s1_q <= SS_IDLE;
            iss_s2_q <= SS_IDLE;
        end else begin
            esck_q   <= {esck_q[1:0], bus.external_sck};
            isck_q   <= {isck_q[1:0], bus.internal_sck};
            emiso_q  <= {emiso_q[0], bus.external_miso};
            ess_s1_q <= bus.external_ss;
            ess_s2_q <= ess_s1_q;
            iss_s1_q <= bus.internal_ss;
            iss_s2_q <= iss_s1_q;
        end
    end

    logic       e_rise;
    logic       i_fall;
    logic       emiso_s;
    logic [1:0] ess_s;
    logic [1:0] iss_s;

    assign e_rise  = esck_q[1] & ~esck_q[2];
    assign i_fall  = ~isck_q[1] & isck_q[2];
    assign emiso_s = emiso_q[1];
    assign ess_s   = ess_s2_q;
    assign iss_s   = iss_s2_q;

    // ------------------------------------------------------------------
    // FIFO state
    // push: one-cycle strobe from capture; accepted unless full, else counted as overflow.
    // pop:  one-cycle strobe from serve; only raised for a frame that selected a valid head.
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]         count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               push;
    logic               push_ok;
    logic               pop;
    logic               fifo_full;
    logic [ENTRY_W-1:0] head_entry;
    logic [DATA_WIDTH-1:0] head_word;
    logic               head_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (count_q == DEPTH_CNT);
    assign push_ok    = push & ~fifo_full;
    assign head_entry = mem_q[rd_ptr_q];
    assign head_word  = head_entry[DATA_WIDTH-1:0];

`ifdef DRAGSTER_READBACK_SLAVE_MATCH_EN
    logic [1:0] head_tag;
    assign head_tag = head_entry[ENTRY_W-1:DATA_WIDTH];
    assign head_ok  = (count_q != 8'd0) && (head_tag == iss_s);
`else
    // Tags still travel through the FIFO so both builds share one storage layout.
    logic [1:0] unused_head_tag;
    assign unused_head_tag = head_entry[ENTRY_W-1:DATA_WIDTH];
    assign head_ok         = (count_q != 8'd0);
`endif

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    cap_state_e            cap_state_q, cap_state_d;
    logic [1:0]            cap_tag_q, cap_tag_d;
    logic [DATA_WIDTH-1:0] cap_word_q, cap_word_d;
    logic [IDX_W-1:0]      cap_idx_q, cap_idx_d;
    logic                  cap_push_q, cap_push_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_state_q <= CIDLE;
            cap_tag_q   <= SS_IDLE;
            cap_word_q  <= '0;
            cap_idx_q   <= '0;
            cap_push_q  <= 1'b0;
        end else begin
            cap_state_q <= cap_state_d;
            cap_tag_q   <= cap_tag_d;
            cap_word_q  <= cap_word_d;
            cap_idx_q   <= cap_idx_d;
            cap_push_q  <= cap_push_d;
        end
    end

    always_comb begin
        cap_state_d = cap_state_q;
        cap_tag_d   = cap_tag_q;
        cap_word_d  = cap_word_q;
        cap_idx_d   = cap_idx_q;
        cap_push_d  = 1'b0;
        case (cap_state_q)
            CIDLE: begin
                if (ess_s != SS_IDLE) begin
                    cap_state_d = CSHIFT;
                    cap_tag_d   = ess_s;
                    cap_idx_d   = '0;
                end
            end
            CSHIFT: begin
                if (ess_s == SS_IDLE) begin
                    cap_state_d = CIDLE;
                end else if (e_rise) begin
                    // LSB first: shifting in from the top lands bit 0 at the bottom after a full word.
                    cap_word_d = {emiso_s, cap_word_q[DATA_WIDTH-1:1]};
                    cap_idx_d  = cap_idx_q + 1'b1;
                    if (cap_idx_q == LAST_IDX) begin
                        cap_state_d = CWAIT;
                        cap_push_d  = 1'b1;
                    end
                end
            end
            CWAIT: begin
                if (ess_s == SS_IDLE) cap_state_d = CIDLE;
            end
            default: cap_state_d = CIDLE;
        endcase
    end

    assign push = cap_push_q;

    // ------------------------------------------------------------------
    // Serve FSM
    // ------------------------------------------------------------------
    srv_state_e            srv_state_q, srv_state_d;
    logic [DATA_WIDTH-1:0] srv_sh_q, srv_sh_d;
    logic [IDX_W-1:0]      srv_idx_q, srv_idx_d;
    logic                  srv_valid_q, srv_valid_d;
    logic                  miso_q, miso_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            srv_state_q <= SIDLE;
            srv_sh_q    <= '0;
            srv_idx_q   <= '0;
            srv_valid_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            srv_state_q <= srv_state_d;
            srv_sh_q    <= srv_sh_d;
            srv_idx_q   <= srv_idx_d;
            srv_valid_q <= srv_valid_d;
            miso_q      <= miso_d;
        end
    end

    always_comb begin
        srv_state_d = srv_state_q;
        srv_sh_d    = srv_sh_q;
        srv_idx_d   = srv_idx_q;
        srv_valid_d = srv_valid_q;
        pop         = 1'b0;
        case (srv_state_q)
            SIDLE: begin
                if (iss_s != SS_IDLE) begin
                    srv_state_d = SSHIFT;
                    srv_idx_d   = '0;
                    srv_valid_d = head_ok;
                    srv_sh_d    = head_ok ? head_word : IDLE_WORD;
                end
            end
            SSHIFT: begin
                if (iss_s == SS_IDLE) begin
                    srv_state_d = SIDLE;
                end else if (i_fall) begin
                    srv_sh_d  = srv_sh_q >> 1;
                    srv_idx_d = srv_idx_q + 1'b1;
                    if (srv_idx_q == LAST_IDX) begin
                        srv_state_d = SDONE;
                        pop         = srv_valid_q;
                    end
                end
            end
            SDONE: begin
                if (iss_s == SS_IDLE) srv_state_d = SIDLE;
            end
            default: srv_state_d = SIDLE;
        endcase
        // Registered from next-state so bit 0 appears on the same edge the frame starts.
        miso_d = (srv_state_d == SSHIFT) ? srv_sh_d[0] : 1'b0;
    end

    // ------------------------------------------------------------------
    // FIFO update
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push_ok && !pop)      count_d = count_q + 8'd1;
        else if (!push_ok && pop) count_d = count_q - 8'd1;
        if (push && fifo_full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {cap_tag_q, cap_word_q};
    end

    assign bus.internal_miso  = miso_q;
    assign bus.buffered_count = count_q;
    assign bus.overflow       = ovf_q;
    assign bus.capture_state  = cap_state_q;
    assign bus.serve_state    = srv_state_q;

endmodule

// File: tb/tb_dragster_spi_readback.sv
// Directed bench for dragster_spi_readback: a queue model of the tagged FIFO predicts
// served words, occupancy and overflow; literal expectations pin the model.
module tb_dragster_spi_readback;

  localparam logic [15:0] IDLE = 16'h0000;

  logic clk;
  logic reset;

  dragster_spi_readback_if bus();

  dragster_spi_readback #(
    .DATA_WIDTH(16),
    .FIFO_DEPTH(16),
    .IDLE_WORD (IDLE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- model and counters ----------------
  logic [17:0] exp_q[$];
  logic        exp_ovf;
  int          busy;
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_head_ok(input logic [1:0] ss);
    bit ok;
    ok = (exp_q.size() > 0);
`ifdef DRAGSTER_READBACK_SLAVE_MATCH_EN
    if (ok && exp_q[0][17:16] != ss) ok = 1'b0;
`else
    if (ss == 2'b11) ok = 1'b0;
`endif
    return ok;
  endfunction

  // ---------------- scoreboard compare process ----------------
  always @(negedge clk) begin
    if (busy == 0 && reset) begin
      check("count", {24'd0, bus.buffered_count}, exp_q.size());
      check("overflow", {31'd0, bus.overflow}, {31'd0, exp_ovf});
      check("miso_idle", {31'd0, bus.internal_miso}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic ext_frame(input logic [1:0] tag, input logic [15:0] word,
                           input int nbits, input int extra);
    busy++;
    @(negedge clk);
    bus.external_ss = tag;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits + extra; i++) begin
      bus.external_miso = (i < nbits) ? word[i] : 1'($urandom_range(0, 1));
      repeat (2) @(negedge clk);
      bus.external_sck = 1'b1;
      repeat (4) @(negedge clk);
      bus.external_sck = 1'b0;
      repeat (2) @(negedge clk);
    end
    bus.external_ss   = 2'b11;
    bus.external_miso = 1'b0;
    repeat (8) @(negedge clk);
    if (nbits >= 16) begin
      if (exp_q.size() >= 16) exp_ovf = 1'b1;
      else exp_q.push_back({tag, word});
    end
    busy--;
  endtask

  task automatic int_frame(input logic [1:0] ss, input int nbits, output logic [15:0] got);
    logic [15:0] exp_w;
    logic [15:0] mask;
    bit          valid;
    busy++;
    valid = model_head_ok(ss);
    exp_w = valid ? exp_q[0][15:0] : IDLE;
    mask  = (nbits >= 16) ? 16'hFFFF : 16'((32'd1 << nbits) - 32'd1);
    got   = '0;
    @(negedge clk);
    bus.internal_ss = ss;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      got[i] = bus.internal_miso;
      bus.internal_sck = 1'b1;
      repeat (4) @(negedge clk);
      bus.internal_sck = 1'b0;
      repeat (4) @(negedge clk);
    end
    check("serve_word", {16'd0, got & mask}, {16'd0, exp_w & mask});
    bus.internal_ss = 2'b11;
    repeat (8) @(negedge clk);
    if (valid && nbits >= 16) void'(exp_q.pop_front());
    busy--;
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] got;
  logic [15:0] got2;

  initial begin
    checks  = 0;
    errors  = 0;
    busy    = 1;
    exp_ovf = 1'b0;
    reset   = 1'b0;
    bus.external_sck  = 1'b0;
    bus.external_ss   = 2'b11;
    bus.external_miso = 1'b0;
    bus.internal_sck  = 1'b0;
    bus.internal_ss   = 2'b11;

    repeat (3) @(negedge clk);
    check("reset_miso", {31'd0, bus.internal_miso}, 32'd0);
    check("reset_count", {24'd0, bus.buffered_count}, 32'd0);
    check("reset_overflow", {31'd0, bus.overflow}, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    busy = 0;

    // capture then serve
    ext_frame(2'b10, 16'hA5C3, 16, 0);
    check("count_after_capture", {24'd0, bus.buffered_count}, 32'd1);
    int_frame(2'b10, 16, got);
    check("served_a5c3", {16'd0, got}, 32'h0000A5C3);
    check("count_after_serve", {24'd0, bus.buffered_count}, 32'd0);

    // empty serve
    int_frame(2'b10, 16, got);
    check("empty_serve", {16'd0, got}, 32'd0);

    // capture abort after 7 bits
    ext_frame(2'b10, 16'hFFFF, 7, 0);
    check("count_after_ext_abort", {24'd0, bus.buffered_count}, 32'd0);

    // serve abort after 9 bits retains head
    ext_frame(2'b10, 16'h1234, 16, 0);
    int_frame(2'b10, 9, got);
    check("partial_bits", {23'd0, got[8:0]}, 32'h00000034);
    check("count_after_int_abort", {24'd0, bus.buffered_count}, 32'd1);
    int_frame(2'b10, 16, got);
    check("served_1234", {16'd0, got}, 32'h00001234);

    // tag handling: head tagged 01 served to ss=10, then to ss=01
    ext_frame(2'b01, 16'h5A5A, 16, 0);
    int_frame(2'b10, 16, got);
    int_frame(2'b01, 16, got);

    // overflow and wrap
    for (int i = 1; i <= 17; i++) ext_frame(2'b10, 16'(i), 16, 0);
    check("count_full", {24'd0, bus.buffered_count}, 32'd16);
    check("overflow_set", {31'd0, bus.overflow}, 32'd1);
    for (int i = 1; i <= 16; i++) begin
      int_frame(2'b10, 16, got);
      check("served_seq", {16'd0, got}, 32'(i));
    end
    ext_frame(2'b10, 16'h0042, 16, 0);
    int_frame(2'b10, 16, got);
    check("served_after_wrap", {16'd0, got}, 32'h00000042);

    // concurrent serve and capture with extended clocks
    ext_frame(2'b10, 16'h0BEE, 16, 0);
    fork
      int_frame(2'b10, 16, got);
      begin
        repeat (6) @(negedge clk);
        ext_frame(2'b10, 16'hC0DE, 16, 3);
      end
    join
    check("served_concurrent", {16'd0, got}, 32'h00000BEE);
    check("count_concurrent", {24'd0, bus.buffered_count}, 32'd1);
    int_frame(2'b10, 16, got2);
    check("served_captured_concurrent", {16'd0, got2}, 32'h0000C0DE);

    // reset mid-frame with overflow still set and a word buffered
    ext_frame(2'b10, 16'hFFFF, 16, 0);
    busy++;
    @(negedge clk);
    bus.external_ss = 2'b10;
    bus.internal_ss = 2'b10;
    repeat (4) @(negedge clk);
    check("miso_before_reset", {31'd0, bus.internal_miso}, {31'd0, exp_q[0][0]});
    bus.external_miso = 1'b1;
    bus.external_sck  = 1'b1;
    bus.internal_sck  = 1'b1;
    repeat (4) @(negedge clk);
    bus.external_sck  = 1'b0;
    bus.internal_sck  = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_miso", {31'd0, bus.internal_miso}, 32'd0);
    check("midreset_count", {24'd0, bus.buffered_count}, 32'd0);
    check("midreset_overflow", {31'd0, bus.overflow}, 32'd0);
    repeat (2) @(negedge clk);
    bus.external_ss   = 2'b11;
    bus.internal_ss   = 2'b11;
    bus.external_miso = 1'b0;
    reset = 1'b1;
    repeat (6) @(negedge clk);
    exp_q.delete();
    exp_ovf = 1'b0;
    busy--;

    // normal operation after reset
    ext_frame(2'b10, 16'h8001, 16, 0);
    int_frame(2'b10, 16, got);
    check("served_after_reset", {16'd0, got}, 32'h00008001);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
